vpe_tf_collector: RTL and testbench

- Downstream neighbour of the VPE traffic-feature fetcher.
- Captures feature words returned by the main feature memory after each fetcher read strobe.
- Packs NUM_FEA features into one flat feature vector.
- Hands the vector to the VPE compute array with a valid/ready handshake, then holds until inference completes (inf_res_v).

---
 rtl/vpe_tf_collector_pkg.sv | 12 +
 rtl/vpe_rd_lat_pipe.sv | 28 ++
 rtl/vpe_tf_collector.sv | 98 +++++++++
 tb/tb_vpe_tf_collector.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpe_tf_collector_pkg.sv
// Shared VPE definitions: default feature geometry and collector state encoding.
package vpe_tf_collector_pkg;

  localparam int FEA_W_DEF   = 8;
  localparam int NUM_FEA_DEF = 16;
  localparam int FEA_VEC_W   = NUM_FEA_DEF * FEA_W_DEF;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

endpackage

// File: rtl/vpe_rd_lat_pipe.sv
// RD_LAT-deep valid delay line for memory-read consumers; flush drops all in-flight strobes.
module vpe_rd_lat_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_v,
  output logic out_v
);

  logic [RD_LAT-1:0] vld_p;
  logic [RD_LAT:0]   shift_in;

  assign shift_in = {vld_p, in_v};
  assign out_v    = shift_in[RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else if (flush) begin
      vld_p <= '0;
    end else begin
      vld_p <= shift_in[RD_LAT-1:0];
    end
  end

endmodule

// File: rtl/vpe_tf_collector.sv
// Packs NUM_FEA returned feature words into one vector, offers it to the compute
// array with valid/ready, then holds it until the inference result comes back.
module vpe_tf_collector
  import vpe_tf_collector_pkg::*;
#(
  parameter int FEA_W   = FEA_W_DEF,
  parameter int NUM_FEA = NUM_FEA_DEF,
  parameter int RD_LAT  = 1,
  parameter int CNT_W   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_fea_en,
  input  logic [FEA_W-1:0]         i_fea_data,
  input  logic                     clr,
  output logic [NUM_FEA*FEA_W-1:0] o_fea_vec,
  output logic                     o_fea_vec_v,
  input  logic                     i_vec_rdy,
  input  logic                     inf_res_v,
  output logic [CNT_W-1:0]         o_fea_cnt,
  output logic                     o_busy,
  output logic                     o_overflow
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_FEA - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_FEA);

  logic       beat;
  logic [1:0] state;

  // clr also flushes strobes still in flight so a stale beat cannot leak into the next vector
  vpe_rd_lat_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_lat_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clr),
    .in_v  (rd_fea_en),
    .out_v (beat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_COLLECT;
      o_fea_cnt   <= '0;
      o_fea_vec   <= '0;
      o_fea_vec_v <= 1'b0;
      o_busy      <= 1'b0;
      o_overflow  <= 1'b0;
    end else if (clr) begin
      state       <= ST_COLLECT;
      o_fea_cnt   <= '0;
      o_fea_vec   <= '0;
      o_fea_vec_v <= 1'b0;
      o_busy      <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (beat && (o_fea_cnt != CNT_FULL)) begin
            for (int k = 0; k < NUM_FEA; k++) begin
              if (o_fea_cnt == CNT_W'(k)) o_fea_vec[k*FEA_W +: FEA_W] <= i_fea_data;
            end
            o_fea_cnt <= o_fea_cnt + CNT_W'(1);
            // valid rises on the same edge that writes the last slot
            if (o_fea_cnt == CNT_LAST) begin
              state       <= ST_PRESENT;
              o_fea_vec_v <= 1'b1;
              o_busy      <= 1'b1;
            end
          end
        end
        ST_PRESENT: begin
          if (beat) o_overflow <= 1'b1;
          if (i_vec_rdy) begin
            state       <= ST_HOLD;
            o_fea_vec_v <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (beat) o_overflow <= 1'b1;
          if (inf_res_v) begin
            state     <= ST_COLLECT;
            o_fea_cnt <= '0;
            o_fea_vec <= '0;
            o_busy    <= 1'b0;
          end
        end
        default: begin
          state       <= ST_COLLECT;
          o_fea_vec_v <= 1'b0;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vpe_tf_collector.sv
// Bench for vpe_tf_collector: one instance at RD_LAT=1, one at RD_LAT=3, each with a
// feature-memory stand-in and a queue-style reference model checked every cycle.
module tb_vpe_tf_collector;

  localparam int FW = 8;
  localparam int NF = 16;
  localparam int CW = 5;
  localparam int VW = FW * NF;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] rd, clr, rdy, inf, vld, busy, ovf;
  logic [FW-1:0] dat [2];
  logic [FW-1:0] req [2];
  logic [CW-1:0] cnt [2];
  logic [VW-1:0] vec [2];

  always #5 clk = ~clk;

  vpe_tf_collector #(.FEA_W(FW), .NUM_FEA(NF), .RD_LAT(1), .CNT_W(CW)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .rd_fea_en(rd[0]), .i_fea_data(dat[0]), .clr(clr[0]),
    .o_fea_vec(vec[0]), .o_fea_vec_v(vld[0]), .i_vec_rdy(rdy[0]), .inf_res_v(inf[0]),
    .o_fea_cnt(cnt[0]), .o_busy(busy[0]), .o_overflow(ovf[0]));

  vpe_tf_collector #(.FEA_W(FW), .NUM_FEA(NF), .RD_LAT(3), .CNT_W(CW)) dut_l3 (
    .clk(clk), .rst_n(rst_n), .rd_fea_en(rd[1]), .i_fea_data(dat[1]), .clr(clr[1]),
    .o_fea_vec(vec[1]), .o_fea_vec_v(vld[1]), .i_vec_rdy(rdy[1]), .inf_res_v(inf[1]),
    .o_fea_cnt(cnt[1]), .o_busy(busy[1]), .o_overflow(ovf[1]));

  int tests = 0;
  int fails = 0;

  // history by age (0 = this cycle) of strobes, clears and requested data
  bit            hs [2][4];
  bit            hc [2][4];
  logic [FW-1:0] hd [2][4];

  // reference model: captured features, vector offered, vector accepted, overflow
  int mv [2][NF];
  int mn [2];
  bit moff [2];
  bit macc [2];
  bit movf [2];

  typedef struct {
    int inst;
    int gap;
    int hold;
    int base;
    int exp_lat;
    int exp_w;
  } fill_vec_t;

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [FW-1:0] slot(input int i, input int k);
    return vec[i][k*FW +: FW];
  endfunction

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 4; a++) begin
        hs[i][a] = 1'b0;
        hc[i][a] = 1'b0;
        hd[i][a] = '0;
      end
      for (int k = 0; k < NF; k++) mv[i][k] = 0;
      mn[i] = 0;
      moff[i] = 1'b0;
      macc[i] = 1'b0;
      movf[i] = 1'b0;
    end
  endtask

  task automatic compare_all(input int i);
    logic [VW-1:0] ev;
    ev = '0;
    for (int k = 0; k < mn[i]; k++) ev[k*FW +: FW] = FW'(mv[i][k]);
    chk((i == 0) ? "model_vec_l1" : "model_vec_l3", vec[i], ev);
    chk((i == 0) ? "model_cnt_l1" : "model_cnt_l3", VW'(cnt[i]), VW'(mn[i]));
    chk((i == 0) ? "model_vld_l1" : "model_vld_l3", VW'(vld[i]), VW'(moff[i]));
    chk((i == 0) ? "model_busy_l1" : "model_busy_l3", VW'(busy[i]), VW'(moff[i] | macc[i]));
    chk((i == 0) ? "model_ovf_l1" : "model_ovf_l3", VW'(ovf[i]), VW'(movf[i]));
  endtask

  // Called at a falling edge with this cycle's inputs set; returns at the next falling edge.
  task automatic step();
    bit beat [2];
    for (int i = 0; i < 2; i++) begin
      for (int a = 3; a > 0; a--) begin
        hs[i][a] = hs[i][a-1];
        hc[i][a] = hc[i][a-1];
        hd[i][a] = hd[i][a-1];
      end
      hs[i][0] = rd[i];
      hc[i][0] = clr[i];
      hd[i][0] = req[i];
      dat[i] = hs[i][lat(i)] ? hd[i][lat(i)] : FW'($urandom);
      // a strobe yields a beat unless a clear hit it anywhere on its way back
      beat[i] = hs[i][lat(i)];
      for (int a = 0; a <= lat(i); a++) if (hc[i][a]) beat[i] = 1'b0;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (clr[i]) begin
        mn[i] = 0; moff[i] = 1'b0; macc[i] = 1'b0; movf[i] = 1'b0;
      end else if (!moff[i] && !macc[i]) begin
        if (beat[i]) begin
          mv[i][mn[i]] = int'(dat[i]);
          mn[i]++;
          if (mn[i] == NF) moff[i] = 1'b1;
        end
      end else if (moff[i]) begin
        if (beat[i]) movf[i] = 1'b1;
        if (rdy[i]) begin moff[i] = 1'b0; macc[i] = 1'b1; end
      end else begin
        if (beat[i]) movf[i] = 1'b1;
        if (inf[i]) begin macc[i] = 1'b0; mn[i] = 0; end
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) compare_all(i);
  endtask

  task automatic run_fill(input int i, input int gap, input int hold, input int base,
                          input int exp_lat, input int exp_w, input bit release_it);
    int c;
    int w;
    int j;
    rdy[i] = (hold == 0);
    for (int k = 0; k < NF; k++) begin
      rd[i] = 1'b1;
      req[i] = FW'(base + k);
      step();
      rd[i] = 1'b0;
      if (k < NF - 1) repeat (gap) step();
    end
    c = 1;
    while (!vld[i] && c < 20) begin
      step();
      c++;
    end
    chk("valid_latency", VW'(c), VW'(exp_lat));
    chk("cnt_full", VW'(cnt[i]), VW'(NF));
    for (int k = 0; k < NF; k++) chk("slot_value", VW'(slot(i, k)), VW'(base + k));
    w = 1;
    j = 0;
    while (vld[i] && w < 30) begin
      if (j == hold) rdy[i] = 1'b1;
      step();
      j++;
      if (vld[i]) w++;
    end
    chk("valid_width", VW'(w), VW'(exp_w));
    rdy[i] = 1'b0;
    chk("busy_in_hold", VW'(busy[i]), VW'(1));
    if (release_it) begin
      inf[i] = 1'b1;
      step();
      inf[i] = 1'b0;
      chk("cnt_release", VW'(cnt[i]), VW'(0));
      chk("vec_release", vec[i], '0);
      chk("busy_release", VW'(busy[i]), VW'(0));
    end
  endtask

  initial begin
    fill_vec_t tbl [5];
    int c;

    tbl[0] = '{inst: 0, gap: 0, hold: 0, base: 'h10, exp_lat: 2, exp_w: 1};
    tbl[1] = '{inst: 0, gap: 0, hold: 5, base: 'h10, exp_lat: 2, exp_w: 6};
    tbl[2] = '{inst: 1, gap: 2, hold: 0, base: 'hA0, exp_lat: 4, exp_w: 1};
    tbl[3] = '{inst: 1, gap: 0, hold: 3, base: 'h40, exp_lat: 4, exp_w: 4};
    tbl[4] = '{inst: 0, gap: 1, hold: 0, base: 'h60, exp_lat: 2, exp_w: 1};

    rst_n = 1'b0;
    rd = '0; clr = '0; rdy = '0; inf = '0;
    req[0] = '0; req[1] = '0; dat[0] = '0; dat[1] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_vld", VW'(vld[i]), VW'(0));
      chk("reset_cnt", VW'(cnt[i]), VW'(0));
      chk("reset_busy", VW'(busy[i]), VW'(0));
      chk("reset_ovf", VW'(ovf[i]), VW'(0));
      chk("reset_vec", vec[i], '0);
    end
    rst_n = 1'b1;
    step();

    for (int t = 0; t < 5; t++) begin
      run_fill(tbl[t].inst, tbl[t].gap, tbl[t].hold, tbl[t].base, tbl[t].exp_lat, tbl[t].exp_w, 1'b1);
      repeat (2) step();
    end

    // extra strobes while holding: overflow, vector untouched, overflow survives release
    run_fill(0, 0, 0, 'h20, 2, 1, 1'b0);
    rd[0] = 1'b1; req[0] = 8'hEE;
    repeat (2) step();
    rd[0] = 1'b0;
    repeat (2) step();
    chk("ovf_in_hold", VW'(ovf[0]), VW'(1));
    chk("ovf_cnt_kept", VW'(cnt[0]), VW'(NF));
    chk("ovf_slot0_kept", VW'(slot(0, 0)), VW'('h20));
    chk("ovf_slot15_kept", VW'(slot(0, 15)), VW'('h2F));
    inf[0] = 1'b1;
    step();
    inf[0] = 1'b0;
    chk("ovf_rel_cnt", VW'(cnt[0]), VW'(0));
    chk("ovf_rel_vec", vec[0], '0);
    chk("ovf_rel_busy", VW'(busy[0]), VW'(0));
    chk("ovf_sticky", VW'(ovf[0]), VW'(1));

    // clr coincident with the 9th beat discards it without flagging overflow
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    chk("clr_ovf_cleared", VW'(ovf[0]), VW'(0));
    for (int k = 0; k < 9; k++) begin
      rd[0] = 1'b1;
      req[0] = FW'('h50 + k);
      step();
    end
    rd[0] = 1'b0;
    chk("clr_pre_cnt", VW'(cnt[0]), VW'(8));
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    chk("clr_cnt", VW'(cnt[0]), VW'(0));
    chk("clr_vec", vec[0], '0);
    chk("clr_ovf", VW'(ovf[0]), VW'(0));
    repeat (3) step();
    chk("clr_beat_gone", VW'(cnt[0]), VW'(0));
    run_fill(0, 0, 0, 'h70, 2, 1, 1'b1);

    // asynchronous reset while the vector is being presented
    rdy[0] = 1'b0;
    for (int k = 0; k < NF; k++) begin
      rd[0] = 1'b1;
      req[0] = FW'('h80 + k);
      step();
    end
    rd[0] = 1'b0;
    c = 0;
    while (!vld[0] && c < 20) begin
      step();
      c++;
    end
    chk("async_pre_vld", VW'(vld[0]), VW'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_vld", VW'(vld[0]), VW'(0));
    chk("async_cnt", VW'(cnt[0]), VW'(0));
    chk("async_vec", vec[0], '0);
    chk("async_busy", VW'(busy[0]), VW'(0));
    chk("async_ovf", VW'(ovf[0]), VW'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_fill(0, 0, 0, 'h90, 2, 1, 1'b1);
    run_fill(1, 0, 0, 'hC0, 4, 1, 1'b1);

    // randomized traffic on both instances against the model
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 2; i++) begin
        rd[i]  = ($urandom_range(0, 99) < 70);
        req[i] = FW'($urandom);
        clr[i] = ($urandom_range(0, 199) < 1);
        rdy[i] = ($urandom_range(0, 99) < 40);
        inf[i] = ($urandom_range(0, 99) < 25);
      end
      step();
    end
    rd = '0; clr = '0; rdy = '0; inf = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
